// File: rtl/aes_pkg.sv
// Shared types and helpers for the word-serial AES-128 loader.
package aes_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 4;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;
  typedef logic [1:0]   wsel_t;

  typedef enum logic [1:0] {
    StFill,
    StSettle,
    StDrain
  } loader_state_t;

  // Big-endian word select: word 0 is bits [127:96].
  function automatic word_t word_get(block_t b, wsel_t idx);
    word_t w;
    case (idx)
      2'd0:    w = b[127:96];
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

  function automatic block_t word_put(block_t b, wsel_t idx, word_t w);
    block_t r;
    r = b;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// Holds the captured ciphertext and returns it as four 32-bit words over valid/ready.
module aes_word_serializer
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  block_t block,
  output word_t  out_data,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   done
);

  block_t ct_reg;
  wsel_t  wcnt;
  logic   last;

  assign last     = (wcnt == wsel_t'(WORDS_PER_BLOCK - 1));
  assign out_data = word_get(ct_reg, wcnt);
  assign done     = out_valid && out_ready && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      ct_reg    <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      ct_reg    <= block;
      wcnt      <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (last) begin
        wcnt      <= '0;
        out_valid <= 1'b0;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_stream_loader.sv
// Word-serial front/back end for a combinational AES-128 core.
// Define AES_LOADER_CBC_EN to chain blocks in CBC mode; otherwise plain ECB and iv_in is unused.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  block_t key_in,
  input  block_t iv_in,
  input  logic   key_load,
  input  word_t  in_data,
  input  logic   in_valid,
  output logic   in_ready,
  output word_t  out_data,
  output logic   out_valid,
  input  logic   out_ready,
  output logic   busy,
  output block_t core_pt,
  output block_t core_key,
  input  block_t core_ct
);

  loader_state_t state;
  wsel_t         wcnt;
  logic [3:0]    scnt;
  block_t        asm_blk;
  block_t        asm_next;
  block_t        pt_next;
  logic          accept;
  logic          capture;
  logic          drain_done;

`ifdef AES_LOADER_CBC_EN
  block_t chain;
  assign pt_next = asm_next ^ chain;
`else
  logic unused_iv;
  assign unused_iv = ^iv_in;
  assign pt_next   = asm_next;
`endif

  // Gated by rst so no word is offered while reset is held.
  assign in_ready = (state == StFill) && !rst;
  assign busy     = (state != StFill);
  assign accept   = in_valid && in_ready;
  assign capture  = (state == StSettle) && (scnt == 4'd0);
  assign asm_next = word_put(asm_blk, wcnt, in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StFill;
      wcnt     <= '0;
      scnt     <= '0;
      asm_blk  <= '0;
      core_pt  <= '0;
      core_key <= '0;
`ifdef AES_LOADER_CBC_EN
      chain    <= '0;
`endif
    end else begin
      case (state)
        StFill: begin
          if (key_load && (wcnt == 2'd0)) begin
            core_key <= key_in;
`ifdef AES_LOADER_CBC_EN
            chain    <= iv_in;
`endif
          end
          if (accept) begin
            asm_blk <= asm_next;
            if (wcnt == wsel_t'(WORDS_PER_BLOCK - 1)) begin
              core_pt <= pt_next;
              state   <= StSettle;
              scnt    <= 4'(SETTLE_CYCLES - 1);
              wcnt    <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        StSettle: begin
          if (capture) begin
            state <= StDrain;
`ifdef AES_LOADER_CBC_EN
            chain <= core_ct;
`endif
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        StDrain: begin
          if (drain_done) state <= StFill;
        end
        default: state <= StFill;
      endcase
    end
  end

  aes_word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .block     (core_ct),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_aes_stream_loader.sv
// Directed bench for aes_stream_loader with a settle-aware stand-in for the AES core.
module tb_aes_stream_loader;

  localparam int SETTLE = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = {128{1'b1}};

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic         key_load;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [127:0] core_pt;
  logic [127:0] core_key;
  logic [127:0] core_ct;

  int total = 0;
  int bad   = 0;

  aes_stream_loader #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .iv_in     (iv_in),
    .key_load  (key_load),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .core_pt   (core_pt),
    .core_key  (core_key),
    .core_ct   (core_ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known FIPS-197 answer for the reference pair, a fixed mixing function otherwise.
  function automatic logic [127:0] aes_ref(logic [127:0] p, logic [127:0] k);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'hc3c3_5a5a_0f0f_a5a5_3c3c_9696_f0f0_1234;
  endfunction

  // Core output is garbage until its inputs have been stable for SETTLE cycles.
  logic [127:0] prev_pt  = '0;
  logic [127:0] prev_key = '0;
  int           age      = 0;
  logic         changed;
  logic         ct_ok;
  assign changed = (core_pt !== prev_pt) || (core_key !== prev_key);
  assign ct_ok   = ((changed ? 1 : age + 1) >= SETTLE);
  assign core_ct = ct_ok ? aes_ref(core_pt, core_key) : 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;

  always @(posedge clk) begin
    age      <= changed ? 1 : (age < 15 ? age + 1 : age);
    prev_pt  <= core_pt;
    prev_key <= core_key;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] b, input int first, input int last, input int maxgap);
    for (int i = first; i <= last; i++) begin
      send_word(b[127-32*i -: 32], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic recv_words(input string tag, input logic [127:0] exp, input int first);
    out_ready = 1'b1;
    for (int i = first; i < 4; i++) begin
      wait_out_valid(tag);
      check($sformatf("%s_w%0d", tag, i), out_data, exp[127-32*i -: 32]);
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    iv_in    = '0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    key_in    = '0;
    iv_in     = '0;
    key_load  = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_core_pt", core_pt, 0);
    check("rst_core_key", core_key, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // FIPS-197 vector with latency
    load_key(FIPS_KEY);
    check("key_loaded", core_key, FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 0);
    check("fips_core_pt", core_pt, FIPS_PT);
    check("fips_busy", busy, 1);
    check("fips_in_ready_settle", in_ready, 0);
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("fips_latency", n, SETTLE + 1);
    recv_words("fips", FIPS_CT, 0);
    check("fips_back_to_fill", in_ready, 1);

    // Backpressure on word 2, with an ignored key_load during DRAIN
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 0);
    wait_out_valid("bp");
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_w%0d", i), out_data, FIPS_CT[127-32*i -: 32]);
      tick();
    end
    out_ready = 1'b0;
    key_in    = KEY2;
    key_load  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", out_data, 32'hd8cdb780);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    key_load = 1'b0;
    check("bp_key_unchanged", core_key, FIPS_KEY);
    recv_words("bp", FIPS_CT, 2);

    // key_load after two words is ignored
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 1, 0);
    key_in   = KEY2;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("kl_ignored_key", core_key, FIPS_KEY);
    send_words(FIPS_PT, 2, 3, 0);
    recv_words("kl", FIPS_CT, 0);

    // Reset mid-DRAIN
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 0);
    wait_out_valid("rd");
    out_ready = 1'b1;
    check("rd_w0", out_data, FIPS_CT[127:96]);
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rd_out_valid", out_valid, 0);
    check("rd_busy", busy, 0);
    check("rd_in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    tick();
    check("rd_in_ready_after", in_ready, 1);
    repeat (3) begin
      check("rd_no_stale_valid", out_valid, 0);
      tick();
    end
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 0);
    recv_words("rd", FIPS_CT, 0);

    // Random input stalls
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 3);
    check("stall_core_pt", core_pt, FIPS_PT);
    recv_words("stall", FIPS_CT, 0);

    // key_load together with the first word: both take effect
    key_in   = KEY2;
    iv_in    = '0;
    key_load = 1'b1;
    send_word(FIPS_PT[127:96], 0);
    key_load = 1'b0;
    check("kw_core_key", core_key, KEY2);
    send_words(FIPS_PT, 1, 3, 1);
    recv_words("kw", aes_ref(FIPS_PT, KEY2), 0);

`ifdef AES_LOADER_CBC_EN
    // CBC chaining: second block XORed with first ciphertext reproduces the FIPS input
    load_key(FIPS_KEY);
    send_words(FIPS_PT, 0, 3, 0);
    recv_words("cbc_b1", FIPS_CT, 0);
    send_words(FIPS_CT ^ FIPS_PT, 0, 3, 0);
    check("cbc_b2_core_pt", core_pt, FIPS_PT);
    recv_words("cbc_b2", FIPS_CT, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
